// File: rtl/uart_tx_stream.sv
// Stream-to-serial UART transmitter: accepts one word per frame over valid/ready
// and shifts out start, data (LSB first), optional parity (UART_TX_PARITY_EN) and stop bits.
module uart_tx_stream #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [2:0]        BIT_ONE   = 3'd1;

  // Elaboration-time guard on the parameter ranges the datapath is sized for.
  if (DATA_BITS < 5 || DATA_BITS > 8 || CLKS_PER_BIT < 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx_stream: illegal parameter value");
  end

  logic [2:0]           r_state;
  logic [BAUD_W-1:0]    r_baud;
  logic [2:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_done;
`ifdef UART_TX_PARITY_EN
  logic                 r_par;
`endif

  logic w_accept;
  logic w_baud_last;
  logic w_data_last;
  logic w_stop_last;

  assign s_ready     = (r_state == ST_IDLE) && !rst;
  assign w_accept    = s_valid && s_ready;
  assign w_baud_last = (r_baud == BAUD_LAST);
  assign w_data_last = (r_bit == DATA_LAST);
  assign w_stop_last = (r_bit == STOP_LAST);

  assign tx      = r_tx;
  assign busy    = (r_state != ST_IDLE);
  assign tx_done = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
      r_baud  <= '0;
      r_bit   <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_baud <= '0;
        r_bit  <= '0;
        r_tx   <= 1'b1;
        if (w_accept) begin
          r_state <= ST_START;
          r_tx    <= 1'b0;
        end
      end else if (!w_baud_last) begin
        r_baud <= r_baud + BAUD_ONE;
      end else begin
        r_baud <= '0;
        case (r_state)
          ST_START: begin
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
            r_bit   <= '0;
          end
          ST_DATA: begin
            if (w_data_last) begin
              r_bit <= '0;
`ifdef UART_TX_PARITY_EN
              r_state <= ST_PARITY;
              r_tx    <= r_par;
`else
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              // Shift happens in the datapath block on this same edge.
              r_bit <= r_bit + BIT_ONE;
              r_tx  <= r_shift[1];
            end
          end
`ifdef UART_TX_PARITY_EN
          ST_PARITY: begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end
`endif
          ST_STOP: begin
            r_tx <= 1'b1;
            if (w_stop_last) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
              r_bit   <= '0;
            end else begin
              r_bit <= r_bit + BIT_ONE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift <= s_data;
`ifdef UART_TX_PARITY_EN
      r_par   <= (^s_data) ^ 1'(PARITY_ODD);
`endif
    end else if (r_state == ST_DATA && w_baud_last && !w_data_last) begin
      r_shift <= r_shift >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream: 8-bit frames, 4 clocks per bit, one stop bit;
// parity frame exercised when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_stream;
  localparam int C    = 4;
  localparam int DB   = 8;
  localparam int SB   = 1;
  localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int N = 1 + DB + P + SB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_hs = 0;

  uart_tx_stream #(
    .DATA_BITS(DB), .CLKS_PER_BIT(C), .STOP_BITS(SB), .PARITY_ODD(PODD)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= DB) return b[k-1];
    if (P == 1 && k == DB + 1) return (^b) ^ (PODD != 0);
    return 1'b1;
  endfunction

  // Offer b at the current negedge and check the whole frame cycle by cycle.
  task automatic frame(input logic [7:0] b, input bit hold, input bit scramble);
    int hs;
    s_valid = 1'b1;
    s_data  = b;
    @(posedge clk);
    hs = cyc;
    for (int k = 0; k < N; k++) begin
      for (int c = 0; c < C; c++) begin
        @(negedge clk);
        if (!hold) s_valid = 1'b0;
        if (scramble) s_data = 8'($urandom);
        chk($sformatf("tx[%02h] bit%0d c%0d", b, k, c), 32'(tx), 32'(exp_bit(b, k)));
        chk($sformatf("busy[%02h] bit%0d c%0d", b, k, c), 32'(busy), 32'd1);
        chk($sformatf("s_ready[%02h] bit%0d c%0d", b, k, c), 32'(s_ready), 32'd0);
        chk($sformatf("tx_done early[%02h] bit%0d c%0d", b, k, c), 32'(tx_done), 32'd0);
      end
    end
    @(negedge clk);
    chk($sformatf("tx_done end[%02h]", b), 32'(tx_done), 32'd1);
    chk($sformatf("busy end[%02h]", b), 32'(busy), 32'd0);
    chk($sformatf("tx end[%02h]", b), 32'(tx), 32'd1);
    chk($sformatf("s_ready end[%02h]", b), 32'(s_ready), 32'd1);
    last_hs = hs;
    $display("[TB] frame %02h handshake at cycle %0d, %0d bits", b, hs, N);
  endtask

  initial begin
    int hs1;
    int d0;
    repeat (3) @(negedge clk);
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset tx_done", 32'(tx_done), 32'd0);
    chk("reset s_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("s_ready after reset", 32'(s_ready), 32'd1);

    // Idle line
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk($sformatf("idle tx %0d", i), 32'(tx), 32'd1);
      chk($sformatf("idle busy %0d", i), 32'(busy), 32'd0);
      chk($sformatf("idle s_ready %0d", i), 32'(s_ready), 32'd1);
      chk($sformatf("idle tx_done %0d", i), 32'(tx_done), 32'd0);
    end
    $display("[TB] idle 100 cycles checked");

    // Single frame 0xA5
    frame(8'hA5, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // Back-to-back with s_valid held
    d0 = done_cnt;
    frame(8'h00, 1'b1, 1'b0);
    hs1 = last_hs;
    frame(8'hFF, 1'b0, 1'b0);
    chk("back-to-back spacing", 32'(last_hs - hs1), 32'(N * C + 1));
    repeat (4) @(negedge clk);
    chk("back-to-back tx_done count", 32'(done_cnt - d0), 32'd2);

    // Backpressure: data scrambled during the frame must not leak in
    frame(8'h5A, 1'b1, 1'b1);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);

`ifdef UART_TX_PARITY_EN
    frame(8'h07, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
`endif

    // Reset during data bit 3
    d0 = done_cnt;
    s_valid = 1'b1;
    s_data  = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (4 * C + 1) @(negedge clk);
    chk("pre-reset tx data bit3", 32'(tx), 32'd1);
    rst = 1'b1;
    #1;
    chk("s_ready during reset", 32'(s_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("tx after mid-frame reset", 32'(tx), 32'd1);
    chk("busy after mid-frame reset", 32'(busy), 32'd0);
    chk("tx_done after mid-frame reset", 32'(tx_done), 32'd0);
    #1;
    chk("s_ready after mid-frame reset", 32'(s_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("no tx_done from aborted frame", 32'(done_cnt - d0), 32'd0);
    $display("[TB] mid-frame reset checked");
    frame(8'h96, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Serial UART transmitter that drains a valid/ready byte stream, such as the master side of the team's synchronous FIFO, and drives an asynchronous serial line. It accepts one word per frame through a standard valid/ready handshake, then shifts it out as start bit, data bits (LSB first), optional parity and stop bits, each lasting a programmable number of clocks. It is the consuming end of the stream: the FIFO buffers, and this block serialises.

## Interface
- `DATA_BITS`, default 8: data bits per frame. Legal range 5..8.
- `CLKS_PER_BIT`, default 868: clocks per serial bit. Minimum 2.
- `STOP_BITS`, default 1: stop bits per frame. Legal values 1 or 2.
- `PARITY_ODD`, default 0: 1 selects odd parity, 0 selects even. Has effect only when `UART_TX_PARITY_EN` is defined.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset. Synchronous and active-high.
- `s_valid` in 1: upstream word valid.
- `s_ready` out 1: block can accept a word.
- `s_data` in DATA_BITS: word to transmit.
- `tx` out 1: serial line. Idles high.
- `busy` out 1: a frame is in progress.
- `tx_done` out 1: one-cycle pulse when a frame completes.

## Operation
- States are IDLE, START, DATA, PARITY (only with the macro) and STOP.
- Reset values: state IDLE, `tx`=1, `busy`=0, `tx_done`=0, and the bit and baud counters 0.
- `s_ready` is 1 only when the state is IDLE and `rst`=0. It is combinational from state and `rst`.
- Handshake: `s_valid && s_ready` at a rising edge.
  - On that edge, `s_data` is captured into the shift register and the state moves to START.
  - `s_data` is ignored at every other time. Changes to `s_data` or `s_valid` during a frame have no effect.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - Its terminal count ends the current bit.
  - Counter width is $clog2(CLKS_PER_BIT).
- State transitions on terminal count:
  - START → DATA.
  - DATA → DATA for bits 0..DATA_BITS-2. The shift register shifts right and `tx` takes the next LSB.
  - After the last data bit: DATA → PARITY when the macro is defined, otherwise DATA → STOP.
  - PARITY → STOP.
  - STOP → STOP until STOP_BITS stop bits have been sent, then STOP → IDLE.
- `tx` is a register:
  - 0 in START.
  - The current data bit in DATA.
  - The parity bit in PARITY.
  - 1 in STOP and IDLE.
- `busy` = (state != IDLE).
- `tx_done` pulses for exactly one cycle, on the edge where STOP → IDLE.
- Reset during a frame:
  - At the first edge with `rst`=1, the state goes to IDLE and `tx` goes to 1.
  - The captured word is discarded and `tx_done` is not pulsed.
  - `s_ready` is 0 for every cycle in which `rst` is high.
- Simultaneous `s_valid` and STOP→IDLE: no handshake occurs on that edge, because `s_ready` was 0. The handshake happens on the next edge.

## Timing
- Definitions:
  - P = 1 if `UART_TX_PARITY_EN` is defined, else 0.
  - N = 1 + DATA_BITS + P + STOP_BITS.
- Handshake at edge T:
  - `tx` falls at T.
  - Bit k (0 = start bit) occupies edges T+k·CLKS_PER_BIT to T+(k+1)·CLKS_PER_BIT.
- STOP→IDLE and the `tx_done` pulse occur at edge T+N·CLKS_PER_BIT.
- The earliest next handshake is at edge T+N·CLKS_PER_BIT+1.
  - The back-to-back frame period is N·CLKS_PER_BIT+1 clocks.
  - The extra clock extends the final stop bit.
- Latency from handshake to start bit on `tx` is 0 cycles (registered at the handshake edge).
- There are no other pipeline stages.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state exists. One parity bit is sent after the data bits.
  - Even parity (`PARITY_ODD`=0): the bit is the XOR of all data bits.
  - Odd parity (`PARITY_ODD`=1): the bit is the inverted XOR.
  - N includes the parity bit.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state and no parity logic.
  - `PARITY_ODD` is ignored.
  - Frames are DATA_BITS-N-STOP_BITS.

## Test plan
- **Single frame**, CLKS_PER_BIT=4, 8N1, send 0xA5 at edge T:
  - `tx` per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1.
  - `tx_done` pulses at T+40.
  - `busy` is 1 from T to T+40.
- **Back-to-back**, `s_valid` held high with 0x00 then 0xFF:
  - Handshakes 41 cycles apart.
  - Second frame `tx` = 0, then eight 1s, then 1.
  - Exactly two `tx_done` pulses.
- **Backpressure**, `s_valid`=1 throughout, `s_data` changed every cycle during frame 1:
  - `s_ready` = 0 for cycles T+1..T+40.
  - Frame 1 carries only the word captured at T.
- **Parity**, macro defined, send 0x07:
  - With `PARITY_ODD`=0 the parity bit is 1; with `PARITY_ODD`=1 it is 0.
  - The frame is 11 bits (44 cycles) and `tx_done` pulses at T+44.
- **Reset during DATA bit 3**, `rst` high 1 cycle:
  - `tx`=1 and `busy`=0 at the next edge, with no `tx_done` pulse.
  - `s_ready`=0 during reset and 1 in the following cycle.
  - A new word then transmits correctly.
- **Idle**, no `s_valid` for 100 cycles after reset: `tx`=1, `busy`=0, `s_ready`=1 and `tx_done`=0 throughout.
